block_drawer: RTL and testbench
===============================

Name: block_drawer

Overview:
- Downstream stage of the block mover: it consumes the block's new top-left position and colour and renders the 48x48 block into the VGA adapter's pixel-write interface, one pixel per clock.
- On each start request it erases the previously drawn block with the background colour, then draws the block at the new position.
- It reports busy/done so the game controller only moves the block after a redraw has completed.

Parameters:
- BLOCK_SIZE, 48, block edge length in pixels
- SCREEN_W, 640, visible width; pixels with x >= SCREEN_W are clipped
- SCREEN_H, 480, visible height; pixels with y >= SCREEN_H are clipped
- BG_COLOUR, 3'b000, colour used for the erase pass

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to redraw at new_x/new_y
- new_x  in  10  top-left x of the new block position
- new_y  in  9  top-left y of the new block position
- colour  in  3  block colour (RGB 1-1-1)
- vga_x  out  10  pixel x to write
- vga_y  out  9  pixel y to write
- vga_colour  out  3  pixel colour to write
- plot  out  1  write strobe for the VGA adapter
- busy  out  1  high while a redraw is in progress
- done  out  1  one-cycle pulse when a redraw completes

Behaviour:
- Single clock domain: reset is synchronous and active-high on clk; all outputs are registered.
- Reset values: vga_x=0, vga_y=0, vga_colour=0, plot=0, busy=0, done=0. Reset returns the FSM to IDLE and clears old_valid.
- FSM states: IDLE, ERASE, DRAW, DONE.
- IDLE:
  - start=1 latches new_x, new_y and colour.
  - If old_valid=1, go to ERASE using the stored old_x/old_y; otherwise go to DRAW.
  - dx and dy are cleared on entry to either state.
- ERASE and DRAW:
  - Emit one pixel per cycle in raster order: dx 0..BLOCK_SIZE-1 is the inner loop, dy is the outer loop.
  - Pixel position is (base_x+dx, base_y+dy). Coordinate widths are 10/9 bits; the sum is computed one bit wider for the clip compare.
  - plot=1 only when the pixel is on screen (x < SCREEN_W and y < SCREEN_H). Clipped pixels still consume their cycle.
  - ERASE uses BG_COLOUR; DRAW uses the latched colour.
  - On the last pixel (dx=dy=BLOCK_SIZE-1): ERASE goes to DRAW with counters cleared; DRAW goes to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - old_x/old_y are set to the drawn position and old_valid is set to 1.
  - Next state is IDLE.
- Timing: start sampled at clock edge T. First pixel output is valid after edge T+1.
  - Without erase: N=BLOCK_SIZE^2=2304 pixel cycles, then done high for the cycle after the last pixel.
  - With erase: 2N=4608 pixel cycles before DONE.
- busy=1 from the cycle after start is accepted through the DONE cycle inclusive. In IDLE: busy=0, plot=0.
- start while busy is ignored, with no queuing. start in the same cycle as reset is ignored.
- Reset mid-operation: plot=0 from the next cycle. The partially drawn block is not erased later, because old_valid=0.

Optional Feature:
- Macro: BLOCK_BORDER_EN.
- When defined, the DRAW pass uses 3'b111 for pixels with dx or dy equal to 0 or BLOCK_SIZE-1, and the latched colour for interior pixels. The ERASE pass is unchanged.
- When undefined, the block is drawn in a solid colour. Timing is identical in both builds.

Decomposition:
- Shared package stacker_pkg holds:
  - the FSM state encoding (IDLE, ERASE, DRAW, DONE)
  - BLOCK_SIZE, SCREEN_W, SCREEN_H, BG_COLOUR
  - the colour constants BLACK=3'b000 and WHITE=3'b111
- One sub-module, block_pixel_counter: dx/dy raster counter with clear, enable, wrap, and a registered last flag. The top FSM instantiates it once and reuses it for both passes.

Test Plan:
- Reset, then start with new_x=0, new_y=432, colour=3'b100 -> no erase; 2304 plot pulses; first pixel (0,432), last (47,479); done 1 cycle after the last pixel; busy falls after done.
- Follow with start, new_x=48 -> 2304 erase pixels over x 0..47 with colour 000, then 2304 pixels over x 48..95 with colour 100; total 4608 plot pulses before done.
- Start with new_x=624, new_y=432 -> 2304 pixel cycles, but only 768 plot pulses (x 624..639); no vga_x >= 640 is ever seen with plot=1.
- start pulses every 100 cycles during a redraw -> all ignored; exactly one done pulse per accepted start.
- Reset asserted 500 cycles into DRAW -> plot=0 on the next cycle, FSM in IDLE; the next start skips erase (2304 pulses only).
- BLOCK_BORDER_EN defined, colour=3'b010 -> pixels at (x0,y0) and (x0+47,y0+20) are 111; pixel at (x0+1,y0+1) is 010.

Source files
------------

// File: rtl/stacker_pkg.sv
// stacker_pkg: shared FSM encoding, geometry and colour constants for the block drawer.
package stacker_pkg;
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;
  localparam int BLOCK_SIZE = 48;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int CW = $clog2(BLOCK_SIZE);
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] BG_COLOUR = BLACK;
endpackage

// File: rtl/block_pixel_counter.sv
// block_pixel_counter: raster dx/dy counter over one block with a registered last-pixel flag.
module block_pixel_counter
  import stacker_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] dx,
  output logic [CW-1:0] dy,
  output logic          last
);
  localparam logic [CW-1:0] MAX = CW'(BLOCK_SIZE - 1);
  logic [CW-1:0] dx_n, dy_n;
  always_comb begin
    dx_n = (dx == MAX) ? '0 : dx + 1'b1;
    dy_n = (dx != MAX) ? dy : (dy == MAX) ? '0 : dy + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      dx <= '0;
      dy <= '0;
      last <= 1'b0;
    end else if (en) begin
      dx <= dx_n;
      dy <= dy_n;
      last <= dx_n == MAX && dy_n == MAX;
    end
  end
endmodule

// File: rtl/block_drawer.sv
// block_drawer: erases the previous block then draws it at the new position, one pixel per clock.
// Define BLOCK_BORDER_EN to draw a white one-pixel border around the block.
module block_drawer
  import stacker_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] new_x,
  input  logic [8:0] new_y,
  input  logic [2:0] colour,
  output logic [9:0] vga_x,
  output logic [8:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);
  state_t state, next_state;
  logic [9:0] lat_x, old_x;
  logic [8:0] lat_y, old_y;
  logic [2:0] lat_colour, draw_colour;
  logic old_valid, last, pix, accept;
  logic [CW-1:0] dx, dy;
  logic [10:0] px;
  logic [9:0] py;
  assign pix = state == ERASE || state == DRAW;
  assign accept = state == IDLE && start;
  assign px = (state == ERASE ? {1'b0, old_x} : {1'b0, lat_x}) + 11'(dx);
  assign py = (state == ERASE ? {1'b0, old_y} : {1'b0, lat_y}) + 10'(dy);
`ifdef BLOCK_BORDER_EN
  localparam logic [CW-1:0] MAX = CW'(BLOCK_SIZE - 1);
  assign draw_colour = (dx == '0 || dx == MAX || dy == '0 || dy == MAX) ? WHITE : lat_colour;
`else
  assign draw_colour = lat_colour;
`endif
  block_pixel_counter u_cnt (
    .clk(clk),
    .reset(reset),
    .clr(state == IDLE || last),
    .en(pix),
    .dx(dx),
    .dy(dy),
    .last(last)
  );
  always_comb begin
    next_state = accept ? (old_valid ? ERASE : DRAW)
               : (state == DONE) ? IDLE
               : !last ? state
               : (state == ERASE) ? DRAW
               : (state == DRAW) ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= next_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_x <= '0;
      vga_y <= '0;
      vga_colour <= '0;
      plot <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      old_valid <= 1'b0;
      lat_x <= '0;
      lat_y <= '0;
      lat_colour <= '0;
      old_x <= '0;
      old_y <= '0;
    end else begin
      if (accept) begin
        lat_x <= new_x;
        lat_y <= new_y;
        lat_colour <= colour;
      end
      if (state == DONE) begin
        old_x <= lat_x;
        old_y <= lat_y;
        old_valid <= 1'b1;
      end
      // Off-screen pixels still take their cycle so pass timing never depends on position.
      plot <= pix && px < 11'(SCREEN_W) && py < 10'(SCREEN_H);
      if (pix) begin
        vga_x <= px[9:0];
        vga_y <= py[8:0];
        vga_colour <= (state == ERASE) ? BG_COLOUR : draw_colour;
      end
      busy <= state != IDLE || accept;
      done <= state == DONE;
    end
  end
endmodule

// File: tb/tb_block_drawer.sv
// tb_block_drawer: scoreboard bench; expected pixels are queued per redraw and checked on every plot.
module tb_block_drawer;
  logic clk = 0, reset = 1, start = 0;
  logic [9:0] new_x = 0;
  logic [8:0] new_y = 0;
  logic [2:0] colour = 0;
  logic [9:0] vga_x;
  logic [8:0] vga_y;
  logic [2:0] vga_colour;
  logic plot, busy, done;
  int checks = 0, failures = 0, plots = 0, dones = 0;
  logic [21:0] exp_q[$];
  bit m_valid = 0;
  logic [9:0] m_x = 0;
  logic [8:0] m_y = 0;

  always #5 clk = ~clk;

  block_drawer dut (
    .clk(clk), .reset(reset), .start(start), .new_x(new_x), .new_y(new_y), .colour(colour),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [21:0] e;
    #1;
    if (done) dones++;
    if (plot) begin
      plots++;
      e = exp_q.size() != 0 ? exp_q.pop_front() : 22'h3fffff;
      chk("pixel", {10'b0, vga_x, vga_y, vga_colour}, {10'b0, e});
      chk("on_screen", {30'b0, vga_x < 10'd640, vga_y < 9'd480}, 32'd3);
    end
  end

  task automatic push_block(input logic [9:0] bx, input logic [8:0] by, input logic [2:0] c, input bit erase);
    for (int dy = 0; dy < 48; dy++)
      for (int dx = 0; dx < 48; dx++) begin
        int x, y;
        logic [2:0] pc;
        x = int'(bx) + dx;
        y = int'(by) + dy;
        pc = erase ? 3'b000 : c;
`ifdef BLOCK_BORDER_EN
        if (!erase && (dx == 0 || dx == 47 || dy == 0 || dy == 47)) pc = 3'b111;
`endif
        if (x < 640 && y < 480) exp_q.push_back({x[9:0], y[8:0], pc});
      end
  endtask

  task automatic redraw(input logic [9:0] nx, input logic [8:0] ny, input logic [2:0] c,
                        input int exp_plots, input bit pulses, input int abort_at);
    int cyc, p0, exp_cyc;
    cyc = 0;
    exp_cyc = m_valid ? 4609 : 2305;
    if (m_valid) push_block(m_x, m_y, 3'b000, 1);
    push_block(nx, ny, c, 0);
    @(negedge clk);
    new_x = nx;
    new_y = ny;
    colour = c;
    start = 1;
    p0 = plots;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    if (abort_at != 0) begin
      while (cyc < abort_at) begin
        @(negedge clk);
        cyc++;
      end
      reset = 1;
      @(negedge clk);
      reset = 0;
      chk("abort_idle", {30'b0, plot, busy}, 32'd0);
      exp_q.delete();
      m_valid = 0;
      return;
    end
    while (!done && cyc < 6000) begin
      start = pulses && (cyc % 100 == 50);
      @(negedge clk);
      cyc++;
    end
    start = 0;
    chk("done_cycle", cyc, exp_cyc);
    chk("plot_count", plots - p0, exp_plots);
    chk("queue_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("done_pulse_busy_fall", {30'b0, done, busy}, 32'd0);
    m_valid = 1;
    m_x = nx;
    m_y = ny;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {8'b0, vga_x, vga_y, vga_colour, plot, busy, done}, 32'd0);
    start = 1;
    new_x = 10'd5;
    @(negedge clk);
    start = 0;
    reset = 0;
    repeat (3) @(negedge clk);
    chk("start_during_reset", {30'b0, busy, plot}, 32'd0);
    redraw(10'd0, 9'd432, 3'b100, 2304, 0, 0);
    redraw(10'd48, 9'd432, 3'b100, 4608, 0, 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    m_valid = 0;
    redraw(10'd624, 9'd432, 3'b001, 768, 0, 0);
    redraw(10'd100, 9'd200, 3'b011, 3072, 1, 0);
    redraw(10'd200, 9'd100, 3'b010, 0, 0, 2804);
    redraw(10'd300, 9'd300, 3'b010, 2304, 0, 0);
    repeat (3) @(negedge clk);
    chk("done_count", dones, 5);
    chk("final_idle", {30'b0, busy, plot}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
